alu32: RTL and testbench
========================

ALU32 -- requirements
Module: alu32

Interface
- No parameters; datapath width fixed at 32 bits.
- REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
- REQ-002 clk  input  1  rising-edge clock for all state.
- REQ-003 rst  input  1  asynchronous active-high reset.
- REQ-004 x  input  32  operand A.
- REQ-005 y  input  32  operand B; used only by ADD, SUB, AND, OR and XOR.
- REQ-006 OpCode  input  12  one-hot operation select, bit index to operation:
  - 0 ADD, 1 SUB, 2 INX, 3 DCX;
  - 4 CPX, 5 SHL, 6 SHR, 7 SRA;
  - 8 AND, 9 OR, 10 XOR, 11 NOT.
- REQ-007 Flags  output  4  registered flags: bit0 ZF, bit1 SF, bit2 OF, bit3 CF.
- REQ-008 z  output  32  registered result.

Function
- REQ-009 z and Flags SHALL update on each rising clk edge from the x, y and OpCode values sampled at that edge (latency 1 cycle, no handshake).
- REQ-010 Results SHALL be:
  - ADD x+y; SUB x-y; INX x+1; DCX x-1; CPX 0-x (two's complement);
  - SHL x<<1, zero fill; SHR x>>1, zero fill; SRA x>>1, x[31] fill;
  - AND x&y; OR x|y; XOR x^y; NOT ~x.
- REQ-011 All arithmetic SHALL be modulo 2^32 (wrap-around).
- REQ-012 ZF SHALL be 1 when the new z equals 0; SF SHALL equal the new z[31]; this holds for every valid op.
- REQ-013 CF SHALL be:
  - ADD, INX: carry-out of bit 31;
  - SUB, DCX, CPX: unsigned borrow (SUB: x<y; DCX: x==0; CPX: x!=0);
  - SHL: x[31]; SHR and SRA: x[0];
  - logic ops: 0.
- REQ-014 OF SHALL be:
  - ADD, SUB, INX, DCX, CPX: two's-complement signed overflow (CPX: x==0x80000000);
  - SHL: x[31]^x[30];
  - SHR, SRA and logic ops: 0.
- REQ-015 OpCode with zero bits set or more than one bit set is illegal: z and Flags SHALL hold their previous values.
- REQ-016 Operand or OpCode changes between clock edges SHALL NOT affect the outputs.

Reset
- REQ-017 While rst=1, z SHALL be 0x00000000 and Flags SHALL be 4'b0000, immediately and without a clock edge.
- REQ-018 Reset asserted mid-operation SHALL discard the pending result.
- REQ-019 The first update after reset release SHALL occur on the first rising clk edge with rst=0.

Configuration
- REQ-020 Macro ALU32_FLAGS_EN:
  - defined: Flags SHALL be computed per REQ-012 to REQ-014;
  - undefined: Flags SHALL be constant 4'b0000, no flag logic SHALL be built, and z behaviour SHALL be unchanged.

Verification
Unless stated otherwise, scenarios use x=0x90000180 and y=0x04000140, with ALU32_FLAGS_EN defined. Flags values are listed as {CF,OF,SF,ZF}.
- REQ-021 Arithmetic:
  - ADD -> z=0x940002C0, Flags=0010;
  - SUB -> z=0x8C000040, Flags=0010;
  - INX -> z=0x90000181, Flags=0010;
  - DCX -> z=0x9000017F, Flags=0010;
  - CPX -> z=0x6FFFFE80, Flags=1000.
- REQ-022 Shifts:
  - SHL -> z=0x20000300, Flags=1100;
  - SHR -> z=0x480000C0, Flags=0000;
  - SRA -> z=0xC80000C0, Flags=0010.
- REQ-023 Logic:
  - AND -> z=0x00000100, Flags=0000;
  - OR -> z=0x940001C0, Flags=0010;
  - XOR -> z=0x940000C0, Flags=0010;
  - NOT -> z=0x6FFFFE7F, Flags=0000.
- REQ-024 Boundaries:
  - ADD 0xFFFFFFFF+0x00000001 -> z=0, Flags=1001;
  - ADD 0x7FFFFFFF+0x00000001 -> z=0x80000000, Flags=0110;
  - CPX x=0x80000000 -> z=0x80000000, Flags=1110.
- REQ-025 Illegal opcode and reset:
  - OpCode=0x000 or 0x003 after an ADD -> outputs unchanged;
  - rst pulse between clock edges -> z=0 and Flags=0 immediately.
- REQ-026 With ALU32_FLAGS_EN undefined, rerun REQ-021 -> identical z values, Flags=0000 throughout.

Source files
------------

// File: rtl/alu32.sv
// 32-bit single-cycle ALU with one-hot opcode, registered result and flags.
// Build option: define ALU32_FLAGS_EN to build the ZF/SF/OF/CF flag logic; otherwise Flags is tied to zero.
module alu32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [11:0] OpCode,
    output logic [3:0]  Flags,
    output logic [31:0] z
);

    localparam logic [11:0] OP_ADD = 12'h001;
    localparam logic [11:0] OP_SUB = 12'h002;
    localparam logic [11:0] OP_INX = 12'h004;
    localparam logic [11:0] OP_DCX = 12'h008;
    localparam logic [11:0] OP_CPX = 12'h010;
    localparam logic [11:0] OP_SHL = 12'h020;
    localparam logic [11:0] OP_SHR = 12'h040;
    localparam logic [11:0] OP_SRA = 12'h080;
    localparam logic [11:0] OP_AND = 12'h100;
    localparam logic [11:0] OP_OR  = 12'h200;
    localparam logic [11:0] OP_XOR = 12'h400;
    localparam logic [11:0] OP_NOT = 12'h800;

    logic [31:0] res;
    logic        legal;

    // Anything other than exactly one opcode bit set leaves the outputs untouched.
    always_comb begin
        res   = '0;
        legal = 1'b1;
        case (OpCode)
            OP_ADD:  res = x + y;
            OP_SUB:  res = x - y;
            OP_INX:  res = x + 32'd1;
            OP_DCX:  res = x - 32'd1;
            OP_CPX:  res = 32'd0 - x;
            OP_SHL:  res = {x[30:0], 1'b0};
            OP_SHR:  res = {1'b0, x[31:1]};
            OP_SRA:  res = {x[31], x[31:1]};
            OP_AND:  res = x & y;
            OP_OR:   res = x | y;
            OP_XOR:  res = x ^ y;
            OP_NOT:  res = ~x;
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z <= '0;
        end else if (legal) begin
            z <= res;
        end
    end

`ifdef ALU32_FLAGS_EN
    logic cf;
    logic of;

    // Carry on add is detected as wrap (result < x); borrow as unsigned compare.
    always_comb begin
        cf = 1'b0;
        of = 1'b0;
        case (OpCode)
            OP_ADD: begin
                cf = (res < x);
                of = (x[31] == y[31]) && (res[31] != x[31]);
            end
            OP_SUB: begin
                cf = (x < y);
                of = (x[31] != y[31]) && (res[31] != x[31]);
            end
            OP_INX: begin
                cf = &x;
                of = (x == 32'h7FFF_FFFF);
            end
            OP_DCX: begin
                cf = (x == 32'd0);
                of = (x == 32'h8000_0000);
            end
            OP_CPX: begin
                cf = |x;
                of = (x == 32'h8000_0000);
            end
            OP_SHL: begin
                cf = x[31];
                of = x[31] ^ x[30];
            end
            OP_SHR:  cf = x[0];
            OP_SRA:  cf = x[0];
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Flags <= '0;
        end else if (legal) begin
            Flags <= {cf, of, res[31], (res == 32'd0)};
        end
    end
`else
    assign Flags = 4'b0000;
`endif

endmodule

// File: tb/tb_alu32.sv
// Self-checking bench for alu32: directed vectors, illegal opcodes, reset pulses and random ops vs. a reference model.
// Flag expectations follow ALU32_FLAGS_EN, matching the DUT build.
module tb_alu32;

`ifdef ALU32_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] x;
    logic [31:0] y;
    logic [11:0] OpCode;
    logic [3:0]  Flags;
    logic [31:0] z;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_z;
    logic [3:0]  exp_f;

    alu32 dut (
        .clk    (clk),
        .rst    (rst),
        .x      (x),
        .y      (y),
        .OpCode (OpCode),
        .Flags  (Flags),
        .z      (z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact arithmetic on 64-bit integers, then wrap to 32 bits.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [11:0] op,
                                  output logic [31:0] rz, output logic [3:0] rf, output bit legal);
        longint up, uq, sp, sq, exact_s;
        bit     is_sub, arith, cf, of;
        int     idx;
        logic [63:0] wide;
        rz = '0;
        rf = '0;
        legal = ($countones(op) == 1);
        if (!legal) return;
        idx = 0;
        for (int i = 0; i < 12; i++) if (op[i]) idx = i;
        up = 0; uq = 0; sp = 0; sq = 0;
        is_sub = 1'b0; arith = 1'b1; cf = 1'b0; of = 1'b0;
        case (idx)
            0: begin up = a; uq = b; sp = $signed(a); sq = $signed(b); end
            1: begin up = a; uq = b; sp = $signed(a); sq = $signed(b); is_sub = 1'b1; end
            2: begin up = a; uq = 1; sp = $signed(a); sq = 1; end
            3: begin up = a; uq = 1; sp = $signed(a); sq = 1; is_sub = 1'b1; end
            4: begin up = 0; uq = a; sp = 0; sq = $signed(a); is_sub = 1'b1; end
            default: arith = 1'b0;
        endcase
        if (arith) begin
            wide    = is_sub ? 64'(up - uq) : 64'(up + uq);
            exact_s = is_sub ? (sp - sq) : (sp + sq);
            rz      = wide[31:0];
            cf      = is_sub ? (up < uq) : ((up + uq) > 64'h0000_0000_FFFF_FFFF);
            of      = (exact_s != longint'($signed(rz)));
        end else begin
            case (idx)
                5: begin rz = a << 1; cf = a[31]; of = a[31] ^ a[30]; end
                6: begin rz = a >> 1; cf = a[0]; end
                7: begin rz = 32'($signed(a) >>> 1); cf = a[0]; end
                8: rz = a & b;
                9: rz = a | b;
                10: rz = a ^ b;
                default: rz = ~a;
            endcase
        end
        rf = FLAGS_ON ? {cf, of, rz[31], (rz == 32'd0)} : 4'b0000;
    endfunction

    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [11:0] op, input string tag);
        logic [31:0] mz;
        logic [3:0]  mf;
        bit          lg;
        x = a;
        y = b;
        OpCode = op;
        @(posedge clk);
        #1;
        model(a, b, op, mz, mf, lg);
        if (lg) begin
            exp_z = mz;
            exp_f = mf;
        end
        check({tag, ".z"}, z, exp_z);
        check({tag, ".flags"}, {28'd0, Flags}, {28'd0, exp_f});
    endtask

    // Directed vectors from the spec; flags listed as {CF,OF,SF,ZF} == Flags[3:0].
    logic [31:0] dx [15];
    logic [31:0] dy [15];
    logic [3:0]  dop [15];
    logic [31:0] dz [15];
    logic [3:0]  df [15];

    initial begin
        dx  = '{32'h90000180, 32'h90000180, 32'h90000180, 32'h90000180, 32'h90000180,
                32'h90000180, 32'h90000180, 32'h90000180, 32'h90000180, 32'h90000180,
                32'h90000180, 32'h90000180, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
        dy  = '{32'h04000140, 32'h04000140, 32'h04000140, 32'h04000140, 32'h04000140,
                32'h04000140, 32'h04000140, 32'h04000140, 32'h04000140, 32'h04000140,
                32'h04000140, 32'h04000140, 32'h00000001, 32'h00000001, 32'h04000140};
        dop = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd0, 4'd0, 4'd4};
        dz  = '{32'h940002C0, 32'h8C000040, 32'h90000181, 32'h9000017F, 32'h6FFFFE80,
                32'h20000300, 32'h480000C0, 32'hC80000C0, 32'h00000100, 32'h940001C0,
                32'h940000C0, 32'h6FFFFE7F, 32'h00000000, 32'h80000000, 32'h80000000};
        df  = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000,
                4'b1100, 4'b0000, 4'b0010, 4'b0000, 4'b0010,
                4'b0010, 4'b0000, 4'b1001, 4'b0110, 4'b1110};
    end

    initial begin
        logic [11:0] op;
        logic [31:0] hold_z;
        logic [3:0]  hold_f;
        rst = 1'b1;
        x = '0;
        y = '0;
        OpCode = 12'h001;
        exp_z = '0;
        exp_f = '0;
        #3;
        check("reset.z", z, 32'd0);
        check("reset.flags", {28'd0, Flags}, 32'd0);
        @(posedge clk);
        #1;
        check("reset_hold.z", z, 32'd0);
        rst = 1'b0;

        // Directed spec vectors, checked against constants.
        for (int i = 0; i < 15; i++) begin
            x = dx[i];
            y = dy[i];
            op = 12'd1 << dop[i];
            OpCode = op;
            @(posedge clk);
            #1;
            check($sformatf("dir%0d.z", i), z, dz[i]);
            check($sformatf("dir%0d.flags", i), {28'd0, Flags}, {28'd0, (FLAGS_ON ? df[i] : 4'b0000)});
            exp_z = dz[i];
            exp_f = FLAGS_ON ? df[i] : 4'b0000;
        end

        // Illegal opcodes after an ADD hold the previous outputs.
        apply(32'h90000180, 32'h04000140, 12'h001, "add_pre");
        hold_z = exp_z;
        hold_f = exp_f;
        apply(32'h12345678, 32'h0000FFFF, 12'h000, "ill000");
        apply(32'hDEADBEEF, 32'h00000001, 12'h003, "ill003");
        check("ill_hold.z", z, hold_z);
        check("ill_hold.flags", {28'd0, Flags}, {28'd0, hold_f});

        // Input changes between edges do not reach the outputs.
        #1 x = 32'hFFFFFFFF; y = 32'h1; OpCode = 12'h001;
        #2 check("glitch.z", z, exp_z);
        check("glitch.flags", {28'd0, Flags}, {28'd0, exp_f});

        // Reset pulse between edges clears outputs at once; first edge after release updates.
        apply(32'h7FFFFFFF, 32'h00000001, 12'h001, "pre_rst");
        x = 32'h00000005; y = 32'h00000003; OpCode = 12'h002;
        rst = 1'b1;
        #1;
        check("rst_pulse.z", z, 32'd0);
        check("rst_pulse.flags", {28'd0, Flags}, 32'd0);
        #1 rst = 1'b0;
        exp_z = '0;
        exp_f = '0;
        apply(32'h00000005, 32'h00000003, 12'h002, "post_rst");

        // Random operations, mostly legal one-hot with some illegal encodings.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'h80000000;
                1: ra = 32'hFFFFFFFF;
                2: ra = 32'h0;
                default: ;
            endcase
            if ($urandom_range(0, 9) == 0) op = 12'($urandom);
            else op = 12'd1 << $urandom_range(0, 11);
            apply(ra, rb, op, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
